simd_retire_merge: RTL
======================

Name: simd_retire_merge

Overview:
- Recombines the scalar and vector instruction streams into one program-ordered stream after the decode-side split.
- The split is made by the 1-bit path select (0 = scalar, 1 = vector) on a 26-bit instruction.
- Each dispatch records its path bit in an order FIFO. Scalar and vector completions are buffered separately and released in dispatch order through one registered output with valid/ready handshake.
- Sits between the scalar/vector execution paths and writeback/retire.

Parameters:
- WIDTH, 26: instruction word width.
- BUF_DEPTH, 4: entries in each per-path completion buffer (power of 2).
- ORD_DEPTH, 8: entries in the order FIFO (power of 2).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-low; sampled on rising clk.
- DispValid  in  1  dispatch event present.
- DispSelec  in  1  path of the dispatched instruction (0 scalar, 1 vector).
- DispReady  out  1  order FIFO can accept.
- SValid  in  1  scalar completion present.
- SInst  in  WIDTH  scalar completed instruction.
- SReady  out  1  scalar buffer not full.
- VValid  in  1  vector completion present.
- VInst  in  WIDTH  vector completed instruction.
- VReady  out  1  vector buffer not full.
- OutValid  out  1  output register holds a word.
- OutInst  out  WIDTH  merged instruction.
- OutSelec  out  1  path the word came from.
- OutReady  in  1  consumer accepts.
- OrdCount  out  clog2(ORD_DEPTH)+1  occupied order-FIFO entries.

Behaviour:
- Reset (rst=0 at an edge):
  - Flushes all three FIFOs (pointers and counts to 0) and clears the output register.
  - Outputs after reset: OutValid=0, OutInst=0, OutSelec=0, OrdCount=0, DispReady=1, SReady=1, VReady=1.
  - Reset overrides any handshake in the same cycle. In-flight entries are discarded, not emitted.
- Order FIFO:
  - Push on DispValid&&DispReady.
  - DispReady = (OrdCount != ORD_DEPTH). It is not relaxed by a same-cycle pop.
  - Pointers wrap modulo ORD_DEPTH.
- Completion buffers:
  - Scalar push on SValid&&SReady; vector push on VValid&&VReady.
  - Ready = not full, with no same-cycle-pop bypass.
  - Pointers wrap modulo BUF_DEPTH.
- Output register, two states:
  - EMPTY (OutValid=0): if the order FIFO is non-empty and the buffer selected by the head bit is non-empty, pop both and load OutInst/OutSelec. Next state is FULL.
  - FULL (OutValid=1):
    - On OutReady=1 with a releasable next entry: reload in the same edge and stay FULL (back-to-back, one word per cycle).
    - On OutReady=1 with nothing releasable: go to EMPTY. OutInst holds its last value.
    - On OutReady=0: OutInst and OutSelec are held stable.
- Ordering:
  - A head entry whose buffer is empty blocks release, even if the other buffer holds data. No reordering.
  - Completions may arrive before their dispatch record. They wait in their buffer.
- Latency:
  - Completion accepted at edge k, with its dispatch already at the order head and the output free: OutValid at edge k+1, i.e. 1 cycle of buffering plus the registered output.
  - Dispatch and completion accepted at the same edge k: same result, OutValid at edge k+1.
- Simultaneous events:
  - Push and pop of the same FIFO in one cycle is legal when not full/empty; count is unchanged.
  - Scalar and vector pushes in the same cycle are both accepted.
- Count widths: counts are clog2(DEPTH)+1 bits. Full is count == DEPTH.
- Completions with no matching dispatch are never dropped. They stall in the buffer until dispatched; this is a system-level invariant and is not checked here.

Test Plan:
- Reset: hold rst=0 two cycles with all valids=1 -> OutValid=0, OutInst=0, OrdCount=0, DispReady/SReady/VReady=1. Nothing is retained after rst=1.
- In-order mix: dispatch S,V,S; SInst 0x0000001 and 0x0000003, VInst 0x0000002, each arriving one cycle after its dispatch; OutReady=1 -> outputs 0x0000001/0, 0x0000002/1, 0x0000003/0 on consecutive cycles.
- Out-of-order arrival: dispatch V then S; SInst 0x00000AA arrives at cycle 2, VInst 0x00000BB at cycle 5 -> OutValid stays 0 until cycle 6. Then 0x00000BB/1, then 0x00000AA/0 on the next cycle.
- Backpressure: OutReady=0; dispatch 5 S; push 6 scalar words 1..6 -> word 1 held in the output register, words 2..5 fill the buffer, SReady=0 on the 6th. Release OutReady=1 -> 1..5 emitted in order, then SReady=1.
- Order FIFO full: 8 dispatches, no completions -> OrdCount=8, DispReady=0, and a 9th DispValid is ignored. Pop one and DispReady returns to 1 the following cycle.
- Reset mid-operation: with 3 entries buffered and OutValid=1, assert rst=0 for one cycle -> all counts 0, OutValid=0. Later completions with no new dispatch are not emitted.

Source files
------------

// File: rtl/simd_retire_merge.sv
// rtl/simd_retire_merge.sv - merges scalar/vector completions back into dispatch order
module simd_retire_merge #(
    parameter int WIDTH     = 26,
    parameter int BUF_DEPTH = 4,
    parameter int ORD_DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       DispValid,
    input  logic                       DispSelec,
    output logic                       DispReady,
    input  logic                       SValid,
    input  logic [WIDTH-1:0]           SInst,
    output logic                       SReady,
    input  logic                       VValid,
    input  logic [WIDTH-1:0]           VInst,
    output logic                       VReady,
    output logic                       OutValid,
    output logic [WIDTH-1:0]           OutInst,
    output logic                       OutSelec,
    input  logic                       OutReady,
    output logic [$clog2(ORD_DEPTH):0] OrdCount
);
    localparam int OPW = $clog2(ORD_DEPTH);
    localparam int OCW = OPW + 1;
    localparam int BPW = $clog2(BUF_DEPTH);
    localparam int BCW = BPW + 1;

    typedef enum logic {ST_EMPTY, ST_FULL} state_t;

    state_t             state_q, state_d;
    logic               ord_mem_q [ORD_DEPTH];
    logic [OPW-1:0]     ord_wr_q, ord_rd_q;
    logic [OCW-1:0]     ord_cnt_q, ord_cnt_d;
    logic [WIDTH-1:0]   s_mem_q [BUF_DEPTH];
    logic [WIDTH-1:0]   v_mem_q [BUF_DEPTH];
    logic [BPW-1:0]     s_wr_q, s_rd_q, v_wr_q, v_rd_q;
    logic [BCW-1:0]     s_cnt_q, s_cnt_d, v_cnt_q, v_cnt_d;
    logic [WIDTH-1:0]   out_inst_q, out_inst_d;
    logic               out_selec_q, out_selec_d;

    logic ord_push, s_push, v_push;
    logic head_sel, head_ok, load;
    logic s_pop, v_pop;

    assign DispReady = (ord_cnt_q != OCW'(ORD_DEPTH));
    assign SReady    = (s_cnt_q != BCW'(BUF_DEPTH));
    assign VReady    = (v_cnt_q != BCW'(BUF_DEPTH));
    assign OrdCount  = ord_cnt_q;
    assign OutValid  = (state_q == ST_FULL);
    assign OutInst   = out_inst_q;
    assign OutSelec  = out_selec_q;

    assign ord_push = DispValid && DispReady;
    assign s_push   = SValid && SReady;
    assign v_push   = VValid && VReady;

    // The head record alone decides which buffer may release; the other buffer never overtakes it.
    assign head_sel = ord_mem_q[ord_rd_q];
    assign head_ok  = (ord_cnt_q != '0) && (head_sel ? (v_cnt_q != '0) : (s_cnt_q != '0));

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (head_ok) begin
                    load    = 1'b1;
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (OutReady) begin
                    if (head_ok) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    assign s_pop = load && !head_sel;
    assign v_pop = load && head_sel;

    always_comb begin
        ord_cnt_d   = ord_cnt_q + OCW'(ord_push) - OCW'(load);
        s_cnt_d     = s_cnt_q + BCW'(s_push) - BCW'(s_pop);
        v_cnt_d     = v_cnt_q + BCW'(v_push) - BCW'(v_pop);
        out_inst_d  = out_inst_q;
        out_selec_d = out_selec_q;
        if (load) begin
            out_inst_d  = head_sel ? v_mem_q[v_rd_q] : s_mem_q[s_rd_q];
            out_selec_d = head_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_EMPTY;
            ord_wr_q    <= '0;
            ord_rd_q    <= '0;
            ord_cnt_q   <= '0;
            s_wr_q      <= '0;
            s_rd_q      <= '0;
            s_cnt_q     <= '0;
            v_wr_q      <= '0;
            v_rd_q      <= '0;
            v_cnt_q     <= '0;
            out_inst_q  <= '0;
            out_selec_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ord_cnt_q   <= ord_cnt_d;
            s_cnt_q     <= s_cnt_d;
            v_cnt_q     <= v_cnt_d;
            out_inst_q  <= out_inst_d;
            out_selec_q <= out_selec_d;
            if (ord_push) ord_wr_q <= ord_wr_q + 1'b1;
            if (load)     ord_rd_q <= ord_rd_q + 1'b1;
            if (s_push)   s_wr_q   <= s_wr_q + 1'b1;
            if (s_pop)    s_rd_q   <= s_rd_q + 1'b1;
            if (v_push)   v_wr_q   <= v_wr_q + 1'b1;
            if (v_pop)    v_rd_q   <= v_rd_q + 1'b1;
        end
    end

    // Storage contents need no reset: the flushed pointers make stale entries unreachable.
    always_ff @(posedge clk) begin
        if (rst && ord_push) ord_mem_q[ord_wr_q] <= DispSelec;
        if (rst && s_push)   s_mem_q[s_wr_q]     <= SInst;
        if (rst && v_push)   v_mem_q[v_wr_q]     <= VInst;
    end
endmodule
